seq_cla_adder: RTL and testbench
================================

# seq_cla_adder

Parametrised multi-cycle adder that generalises the 4-bit carry-lookahead adder to WIDTH bits. It reuses one CHUNK-bit CLA slice across WIDTH/CHUNK clock cycles, holding the inter-chunk carry in a register. A start/busy/done handshake drives it, and it produces sum, carry-out and signed overflow. It serves as the area-lean adder option for the 32-bit datapath, where single-cycle latency is not required.

## Interface
- WIDTH, 32: operand and sum width. Must be a positive multiple of CHUNK.
- CHUNK, 4: bits per CLA slice per cycle. N = WIDTH/CHUNK cycles per add.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  operand A; captured on the accepted start.
- B  input  WIDTH  operand B; captured on the accepted start.
- cin  input  1  carry-in; captured on the accepted start.
- sub  input  1  subtract select; present only with SEQ_CLA_SUB_EN.
- busy  output  1  high while chunks are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY when start=1.
  - On that edge: latch A, B and cin into working registers.
  - Clear chunk index idx=0.
  - Load the carry register with cin.
- BUSY, each edge: one CHUNK-bit CLA of a_reg[idx], b_reg[idx] and the carry register.
  - Write the slice sum into work_sum[idx*CHUNK +: CHUNK].
  - Load the slice carry-out into the carry register.
  - idx increments.
  - On the slice where idx=N-1, also record the carry into the MSB.
- BUSY -> DONE after the edge that processes idx=N-1.
  - sum, cout and overflow are updated from the working registers on that same edge.
- DONE lasts one cycle with done=1.
  - start=1 in DONE is accepted: back to BUSY, same latch behaviour as from IDLE.
  - Otherwise go to IDLE.
- start in BUSY is ignored. The operation in flight is not disturbed.
- sum, cout and overflow change only on a completing edge. They hold their value through IDLE and through the next operation until it completes.
- A, B and cin may change freely after the accepting edge.
- Width rule: sum is the result mod 2^WIDTH and cout is bit WIDTH of the full result. No saturation.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, idx=0, carry register=0.
- rst has priority over start. Asserting rst mid-BUSY aborts the operation. Next cycle shows busy=0, done=0 and sum/cout/overflow=0.
- Start sampled at edge k:
  - busy=1 during cycles k+1 .. k+N.
  - done=1 during cycle k+N+1. The result is visible in the same cycle.
  - Latency is N+1 cycles from the start edge to done. With WIDTH=32 and CHUNK=4, that is 9.
- Back-to-back operation (start held high) gives one result every N+1 cycles.
- WIDTH=CHUNK (N=1) is legal: one BUSY cycle, then DONE.

## Configuration
- SEQ_CLA_SUB_EN defined:
  - The sub port exists.
  - When sub=1 at the accepted start, the block latches ~B and forces the initial carry to 1, ignoring cin. The result is A-B.
  - cout=1 means no borrow.
  - overflow reports signed subtraction overflow.
- SEQ_CLA_SUB_EN undefined:
  - The sub port is absent.
  - The block is add-only with cin as supplied.

## Test plan
- WIDTH=4, CHUNK=4, A=4'b1010, B=4'b1010, cin=1 -> sum=4'b0101, cout=1, overflow=1, done one cycle after busy.
- WIDTH=32, CHUNK=4: A=32'hFFFFFFFF, B=32'h00000001, cin=0 -> sum=32'h0, cout=1, overflow=0. Carry ripples through all 8 chunks; done exactly 9 cycles after the start edge.
- A=32'h7FFFFFFF, B=32'h00000001, cin=0 -> sum=32'h80000000, cout=0, overflow=1.
- A=32'hAAAAAAAA, B=32'h55555555, cin=0:
  - The bench changes A and B and pulses start during BUSY.
  - Required: sum=32'hFFFFFFFF, cout=0.
  - Required: the second start is ignored and produces no extra done.
- Start with A=32'h12345678, B=32'h1; assert rst during the 3rd BUSY cycle -> next cycle busy=0, done=0, sum=0. No done pulse follows.
- With SEQ_CLA_SUB_EN: A=5, B=13, sub=1 -> sum=32'hFFFFFFF8, cout=0, overflow=0. Then A=13, B=5, sub=1 back-to-back from DONE -> sum=8, cout=1.

Source files
------------

// File: rtl/seq_cla_adder.sv
// seq_cla_adder: multi-cycle WIDTH-bit adder that reuses one CHUNK-bit
// carry-lookahead slice for WIDTH/CHUNK cycles, carrying between chunks
// through a register. Handshake: start / busy / done.
// Optional feature macro: SEQ_CLA_SUB_EN adds the sub port (A-B when sub=1).
module seq_cla_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
`ifdef SEQ_CLA_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int N = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_q, state_d;
   logic               accept;
   logic               last;
   logic [WIDTH-1:0]   a_reg, b_reg, work_sum, next_work;
   logic               carry_q;
   logic [IDX_W-1:0]   idx_q;
   logic [CHUNK+1:0]   slice;

   // One CLA slice. Returns {carry out, carry into slice MSB, slice sum}.
   // Each carry is the full lookahead sum of products of g/p terms.
   function automatic logic [CHUNK+1:0] cla_slice(input logic [CHUNK-1:0] a,
                                                  input logic [CHUNK-1:0] b,
                                                  input logic             c0);
      logic [CHUNK-1:0] g, p;
      logic [CHUNK:0]   c;
      logic             prod;
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = c0;
      for (int i = 0; i < CHUNK; i++) begin
         for (int j = 0; j <= i + 1; j++) begin
            prod = (j == 0) ? c0 : g[j-1];
            for (int k = j; k <= i; k++) prod = prod & p[k];
            c[i+1] = c[i+1] | prod;
         end
      end
      return {c[CHUNK], c[CHUNK-1], p ^ c[CHUNK-1:0]};
   endfunction

   assign accept = start && (state_q == IDLE || state_q == DONE);
   assign last   = (state_q == BUSY) && (idx_q == LAST_IDX);
   assign busy   = (state_q == BUSY);
   assign done   = (state_q == DONE);

   // Current slice result and the working sum with that slice merged in.
   always_comb begin
      slice     = cla_slice(a_reg[idx_q*CHUNK +: CHUNK], b_reg[idx_q*CHUNK +: CHUNK], carry_q);
      next_work = work_sum;
      next_work[idx_q*CHUNK +: CHUNK] = slice[CHUNK-1:0];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; start is only honoured in IDLE or DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = BUSY;
         BUSY:    if (idx_q == LAST_IDX) state_d = DONE;
         DONE:    state_d = start ? BUSY : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control state and result registers; results move only on the completing edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         carry_q  <= 1'b0;
         idx_q    <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
`ifdef SEQ_CLA_SUB_EN
         carry_q <= sub ? 1'b1 : cin;
`else
         carry_q <= cin;
`endif
         idx_q   <= '0;
      end else if (state_q == BUSY) begin
         carry_q <= slice[CHUNK+1];
         idx_q   <= last ? '0 : idx_q + 1'b1;
         if (last) begin
            sum      <= next_work;
            cout     <= slice[CHUNK+1];
            overflow <= slice[CHUNK+1] ^ slice[CHUNK];
         end
      end
   end

   // Operand capture and working sum; these need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_reg <= A;
`ifdef SEQ_CLA_SUB_EN
         b_reg <= sub ? ~B : B;
`else
         b_reg <= B;
`endif
      end
      if (state_q == BUSY) work_sum <= next_work;
   end

endmodule

// File: tb/tb_seq_cla_adder.sv
// tb_seq_cla_adder: directed bench for seq_cla_adder, a 32-bit/4-bit-chunk
// instance plus a single-chunk 4-bit instance. Covers SEQ_CLA_SUB_EN when defined.
module tb_seq_cla_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a, b;
   logic        cin;
   logic        busy, done, cout, overflow;
   logic [31:0] sum;
`ifdef SEQ_CLA_SUB_EN
   logic        sub;
`endif

   logic        start4;
   logic [3:0]  a4, b4;
   logic        cin4;
   logic        busy4, done4, cout4, overflow4;
   logic [3:0]  sum4;

   int total = 0;
   int passed = 0;
   int lat;
   int pulses;

   always #5 clk = ~clk;

   seq_cla_adder #(.WIDTH(32), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .cin(cin),
`ifdef SEQ_CLA_SUB_EN
      .sub(sub),
`endif
      .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
   );

   seq_cla_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .cin(cin4),
`ifdef SEQ_CLA_SUB_EN
      .sub(1'b0),
`endif
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(overflow4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Called one step after the start edge; returns cycles from start edge to done.
   task automatic wait_done(output int cycles);
      cycles = 1;
      while (!done && cycles < 20) begin
         tick();
         cycles++;
      end
   endtask

   // Single add on the 32-bit instance, start dropped after acceptance.
   task automatic run32(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                        output int cycles);
      a = av; b = bv; cin = cv; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(cycles);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef SEQ_CLA_SUB_EN
      sub = 1'b0;
`endif
      tick(); tick();
      rst = 1'b0;

      // Reset state
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout_ovf", {cout, overflow}, 0);
      check("rst4_outs", {busy4, done4, cout4, overflow4, sum4}, 0);

      // Single-chunk instance: 1010 + 1010 + 1
      a4 = 4'b1010; b4 = 4'b1010; cin4 = 1'b1; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      check("w4_busy", {busy4, done4}, 2'b10);
      tick();
      check("w4_done", {busy4, done4}, 2'b01);
      check("w4_sum", sum4, 4'b0101);
      check("w4_cout_ovf", {cout4, overflow4}, 2'b11);
      tick();
      check("w4_idle", {busy4, done4}, 2'b00);

      // Full carry ripple through every chunk
      a = 32'hFFFFFFFF; b = 32'h1; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("ripple_busy", busy, 1);
      wait_done(lat);
      check("ripple_lat", lat, 9);
      check("ripple_sum", sum, 32'h0);
      check("ripple_cout_ovf", {cout, overflow}, 2'b10);
      tick();
      check("ripple_done_pulse", done, 0);

      // Positive overflow
      run32(32'h7FFFFFFF, 32'h1, 1'b0, lat);
      check("povf_lat", lat, 9);
      check("povf_sum", sum, 32'h80000000);
      check("povf_cout_ovf", {cout, overflow}, 2'b01);
      tick();

      // Carry-in only
      run32(32'h0, 32'h0, 1'b1, lat);
      check("cin_sum", sum, 32'h1);
      check("cin_cout_ovf", {cout, overflow}, 2'b00);
      tick();

      // Operand changes and a start pulse during BUSY are ignored
      a = 32'hAAAAAAAA; b = 32'h55555555; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a = 32'h11111111; b = 32'h22222222; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 3;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      check("ign_lat", lat, 9);
      check("ign_sum", sum, 32'hFFFFFFFF);
      check("ign_cout_ovf", {cout, overflow}, 2'b00);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done || busy) pulses++;
      end
      check("ign_no_extra", pulses, 0);

      // Reset during the third BUSY cycle aborts the operation
      a = 32'h12345678; b = 32'h1; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      check("abort_hold_sum", sum, 32'hFFFFFFFF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_flags", {busy, done}, 2'b00);
      check("abort_sum", sum, 32'h0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) pulses++;
      end
      check("abort_no_done", pulses, 0);

      // Back-to-back with start held high
      a = 32'h1; b = 32'h2; cin = 1'b0; start = 1'b1;
      tick();
      a = 32'h100; b = 32'h200;
      wait_done(lat);
      check("b2b_first_sum", sum, 32'h3);
      tick();
      start = 1'b0;
      check("b2b_rebusy", {busy, done}, 2'b10);
      check("b2b_hold_sum", sum, 32'h3);
      lat = 1;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      check("b2b_lat", lat, 9);
      check("b2b_second_sum", sum, 32'h300);
      tick();

`ifdef SEQ_CLA_SUB_EN
      // Subtraction with borrow, then the reverse back-to-back from DONE
      a = 32'd5; b = 32'd13; cin = 1'b0; sub = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(lat);
      check("sub_neg_sum", sum, 32'hFFFFFFF8);
      check("sub_neg_cout_ovf", {cout, overflow}, 2'b00);
      a = 32'd13; b = 32'd5; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(lat);
      check("sub_pos_lat", lat, 9);
      check("sub_pos_sum", sum, 32'd8);
      check("sub_pos_cout_ovf", {cout, overflow}, 2'b10);
      sub = 1'b0;
      tick();
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
